// File: rtl/kara_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kara_pkg
// Brief    : Shared types and helpers for the sequential Karatsuba multiplier:
//            FSM state encoding, half width, abs-difference helper.
// Revision : 1.0 - initial release
// ============================================================================
package kara_pkg;

  // Half operand width, matching the external 16x16 sub-multiplier.
  localparam int H = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MID  = 3'd3,
    SUM  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Magnitude of a difference plus the borrow that tells its sign.
  typedef struct packed {
    logic         borrow;
    logic [H-1:0] mag;
  } absdiff_t;

  // |a - b| as an H-bit magnitude; borrow is set when a < b.
  function automatic absdiff_t abs_diff(input logic [H-1:0] a, input logic [H-1:0] b);
    absdiff_t r;
    r.borrow = (a < b);
    r.mag    = r.borrow ? (b - a) : (a - b);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kara_recombine.sv
`default_nettype none
// ============================================================================
// Module   : kara_recombine
// Brief    : Combinational subtractive-Karatsuba recombination.
//            z1 = z0 + z2 +/- m in 2*HW+2 signed bits,
//            p  = (z2 << 2*HW) + (z1 << HW) + z0, kept modulo 2^(4*HW).
// Revision : 1.0 - initial release
// ============================================================================
module kara_recombine
  import kara_pkg::*;
#(
  parameter int HW = H
) (
  input  logic [2*HW-1:0] z0_i,
  input  logic [2*HW-1:0] z2_i,
  input  logic [2*HW-1:0] m_i,
  input  logic            s_i,
  output logic [4*HW-1:0] p_o
);

  logic [2*HW+1:0] z0_e;
  logic [2*HW+1:0] z2_e;
  logic [2*HW+1:0] m_e;
  logic [2*HW+1:0] z1;
  logic [4*HW-1:0] z1_sx;
  logic [4*HW-1:0] z2_sh;

  // Middle term in two's complement, then the shifted sum. Only the low
  // 4*HW bits of the wider sum are kept, and those bits do not depend on
  // anything above them, so the sum is formed directly at the output width.
  always_comb begin
    z0_e  = {2'b00, z0_i};
    z2_e  = {2'b00, z2_i};
    m_e   = {2'b00, m_i};
    z1    = s_i ? (z0_e + z2_e - m_e) : (z0_e + z2_e + m_e);
    z1_sx = {{(2*HW-2){z1[2*HW+1]}}, z1};
    z2_sh = {z2_i, {(2*HW){1'b0}}};
    p_o   = z2_sh + (z1_sx << HW) + {{(2*HW){1'b0}}, z0_i};
  end

endmodule
`default_nettype wire

// File: rtl/karatsuba_seq32.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba_seq32
// Brief    : Sequential W x W unsigned multiplier using subtractive Karatsuba.
//            Time-shares one external H x H multiplier over three
//            sub-products (LO, HI, MID), then recombines into 2W bits.
//            Build option KARA_MUL_PIPE_EN registers mul_p on entry and
//            spends two cycles in each of LO/HI/MID.
// Revision : 1.0 - initial release
// ============================================================================
module karatsuba_seq32
  import kara_pkg::*;
#(
  parameter int W = 2 * H  // must equal 2*H of the package
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic [W/2-1:0]   mul_a,
  output logic [W/2-1:0]   mul_b,
  input  logic [W-1:0]     mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p
);

  localparam int HW = W / 2;

  state_e            state_q, state_d;
  logic [W-1:0]      x_q, x_d;
  logic [W-1:0]      y_q, y_d;
  logic [W-1:0]      z0_q, z0_d;
  logic [W-1:0]      z2_q, z2_d;
  logic [W-1:0]      m_q, m_d;
  logic              s_q, s_d;
  logic [2*W-1:0]    p_q, p_d;

  logic [W-1:0]      prod;   // sub-product as seen by the capture logic
  logic              cap;    // capture strobe inside LO/HI/MID
  logic [2*W-1:0]    p_rec;
  absdiff_t          dx;
  absdiff_t          dy;

  // Differences for the middle product: |xh-xl| and |yl-yh| with borrows.
  assign dx = abs_diff(x_q[W-1:HW], x_q[HW-1:0]);
  assign dy = abs_diff(y_q[HW-1:0], y_q[W-1:HW]);

`ifdef KARA_MUL_PIPE_EN
  logic         phase_q, phase_d;
  logic [W-1:0] mulp_q;

  assign prod = mulp_q;
  assign cap  = phase_q;

  // Input register on mul_p plus the drive/capture phase bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulp_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      mulp_q  <= mul_p;
      phase_q <= phase_d;
    end
  end

  // Phase toggles only while a sub-product step is in progress.
  always_comb begin
    phase_d = 1'b0;
    if (state_q == LO || state_q == HI || state_q == MID) begin
      phase_d = ~phase_q;
    end
  end
`else
  assign prod = mul_p;
  assign cap  = 1'b1;
`endif

  kara_recombine #(
    .HW (HW)
  ) u_recombine (
    .z0_i (z0_q),
    .z2_i (z2_q),
    .m_i  (m_q),
    .s_i  (s_q),
    .p_o  (p_rec)
  );

  // Next-state, sub-multiplier operands and handshake outputs.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z0_d      = z0_q;
    z2_d      = z2_q;
    m_d       = m_q;
    s_d       = s_q;
    p_d       = p_q;
    mul_a     = '0;
    mul_b     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          state_d = LO;
        end
      end
      LO: begin
        mul_a = x_q[HW-1:0];
        mul_b = y_q[HW-1:0];
        if (cap) begin
          z0_d    = prod;
          state_d = HI;
        end
      end
      HI: begin
        mul_a = x_q[W-1:HW];
        mul_b = y_q[W-1:HW];
        if (cap) begin
          z2_d    = prod;
          state_d = MID;
        end
      end
      MID: begin
        mul_a = dx.mag;
        mul_b = dy.mag;
        if (cap) begin
          m_d     = prod;
          // A zero difference makes m zero; the sign is then forced positive.
          s_d     = (dx.borrow ^ dy.borrow) & (|dx.mag) & (|dy.mag);
          state_d = SUM;
        end
      end
      SUM: begin
        p_d     = p_rec;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      m_q     <= '0;
      s_q     <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      m_q     <= m_d;
      s_q     <= s_d;
      p_q     <= p_d;
    end
  end

  assign p = p_q;

endmodule
`default_nettype wire
